mul_share_sched: RTL and testbench

- Sequencer and arbiter for the shared nibble-serial 8x8 multiply datapath (4-bit multiplier, nibble muxes, shifter, 16-bit adder, accumulator register).
- Two requesters issue operand pairs over valid/ready; the block grants them round-robin and latches the granted operands.
- It then drives the four partial-product steps and returns the 16-bit product, tagged with the requester id, over a valid/ready response port.

---
 rtl/mul_share_sched_if.sv | 54 +++++
 rtl/mul_share_sched.sv | 174 +++++++++++++++++
 tb/tb_mul_share_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_sched_if.sv
// rtl/mul_share_sched_if.sv - request, response and datapath-control bundle for mul_share_sched
// slave modport (scheduler side):
//    req0_*/req1_* : operand pairs in (valid, a, b), ready out
//    dp_*          : latched operands, nibble selects, shift select, accumulator clear/enable out; dp_acc in
//    rsp_*         : product with requester id out (valid, id, data), ready in
// master modport: the same signals seen from the requesters, datapath and consumer.

interface mul_share_sched_if;
   logic        req0_valid;
   logic [7:0]  req0_a;
   logic [7:0]  req0_b;
   logic        req0_ready;

   logic        req1_valid;
   logic [7:0]  req1_a;
   logic [7:0]  req1_b;
   logic        req1_ready;

   logic [7:0]  dp_a;
   logic [7:0]  dp_b;
   logic        dp_sela;
   logic        dp_selb;
   logic [1:0]  dp_shift_sel;
   logic        dp_acc_clr;
   logic        dp_acc_en;
   logic [15:0] dp_acc;

   logic        rsp_valid;
   logic        rsp_id;
   logic [15:0] rsp_data;
   logic        rsp_ready;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_a, req1_b,
      output req1_ready,
      output dp_a, dp_b, dp_sela, dp_selb, dp_shift_sel, dp_acc_clr, dp_acc_en,
      input  dp_acc,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_a, req1_b,
      input  req1_ready,
      input  dp_a, dp_b, dp_sela, dp_selb, dp_shift_sel, dp_acc_clr, dp_acc_en,
      output dp_acc,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready
   );
endinterface

// File: rtl/mul_share_sched.sv
// rtl/mul_share_sched.sv - round-robin sequencer for the shared nibble-serial 8x8 multiplier
// Ports:
//    clk      : rising-edge clock
//    rst      : synchronous reset, active-low
//    bus      : mul_share_sched_if.slave (two requesters, datapath controls, response)
//    busy     : high whenever the FSM is not idle
//    done_cnt : number of responses handed off, wraps at 256
// Parameter RR_INIT selects the requester that wins a tie first after reset.

module mul_share_sched #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   mul_share_sched_if.slave bus,
   output logic             busy,
   output logic [7:0]       done_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_P0,
      S_P1,
      S_P2,
      S_P3,
      S_CAP,
      S_RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        ptr;         // requester that wins when both are valid
   logic        gnt0;
   logic        gnt1;
   logic        ready0;
   logic        ready1;
   logic        accept;
   logic        rsp_fire;

   logic        acc_clr;
   logic        acc_en;
   logic        sela;
   logic        selb;
   logic [1:0]  shift_sel;
   logic        rsp_valid;

   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic        id_q;
   logic [15:0] data_q;
   logic [7:0]  done_q;

   // A lone requester always wins; on a tie the pointer decides.
   assign gnt0 = bus.req0_valid && (!bus.req1_valid || !ptr);
   assign gnt1 = bus.req1_valid && (!bus.req0_valid ||  ptr);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Partial-product order: alo*blo, ahi*blo<<4, alo*bhi<<4, ahi*bhi<<8.
   always_comb begin
      state_nxt = state;
      ready0    = 1'b0;
      ready1    = 1'b0;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;
      sela      = 1'b0;
      selb      = 1'b0;
      shift_sel = 2'b00;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            // Readies are held low while reset is asserted so no handshake
            // is ever signalled on an edge that throws the operands away.
            ready0 = rst && gnt0;
            ready1 = rst && gnt1;
            if (ready0 || ready1) begin
               state_nxt = S_CLR;
            end
         end
         S_CLR: begin
            acc_clr   = 1'b1;
            state_nxt = S_P0;
         end
         S_P0: begin
            acc_en    = 1'b1;
            state_nxt = S_P1;
         end
         S_P1: begin
            acc_en    = 1'b1;
            sela      = 1'b1;
            shift_sel = 2'b01;
            state_nxt = S_P2;
         end
         S_P2: begin
            acc_en    = 1'b1;
            selb      = 1'b1;
            shift_sel = 2'b01;
            state_nxt = S_P3;
         end
         S_P3: begin
            acc_en    = 1'b1;
            sela      = 1'b1;
            selb      = 1'b1;
            shift_sel = 2'b10;
            state_nxt = S_CAP;
         end
         S_CAP: begin
            state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign accept   = ready0 | ready1;
   assign rsp_fire = rsp_valid & bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr    <= RR_INIT;
         a_q    <= 8'd0;
         b_q    <= 8'd0;
         id_q   <= 1'b0;
         data_q <= 16'd0;
         done_q <= 8'd0;
      end else begin
         if (accept) begin
            a_q  <= ready1 ? bus.req1_a : bus.req0_a;
            b_q  <= ready1 ? bus.req1_b : bus.req0_b;
            id_q <= ready1;
            ptr  <= !ready1;      // the loser of this grant leads next time
         end
         // The accumulator already holds the P3 sum during CAP.
         if (state == S_CAP) begin
            data_q <= bus.dp_acc;
         end
         if (rsp_fire) begin
            done_q <= done_q + 8'd1;
         end
      end
   end

   assign bus.req0_ready   = ready0;
   assign bus.req1_ready   = ready1;
   assign bus.dp_a         = a_q;
   assign bus.dp_b         = b_q;
   assign bus.dp_sela      = sela;
   assign bus.dp_selb      = selb;
   assign bus.dp_shift_sel = shift_sel;
   assign bus.dp_acc_clr   = acc_clr;
   assign bus.dp_acc_en    = acc_en;
   assign bus.rsp_valid    = rsp_valid;
   assign bus.rsp_id       = id_q;
   assign bus.rsp_data     = data_q;

   assign busy     = (state != S_IDLE);
   assign done_cnt = done_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// tb/tb_mul_share_sched.sv - scoreboard bench for mul_share_sched with a behavioural nibble datapath

module tb_mul_share_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [7:0]  done_cnt;

   mul_share_sched_if bus ();

   mul_share_sched #(.RR_INIT(1'b0)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .done_cnt (done_cnt)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [16:0] sb_q[$];
   logic [7:0]  exp_done = 8'd0;
   logic [15:0] acc_m    = 16'd0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] part(input logic [7:0] a, input logic [7:0] b,
                                        input logic sa, input logic sb, input logic [1:0] sh);
      logic [3:0]  na;
      logic [3:0]  nb;
      logic [15:0] p;
      na = sa ? a[7:4] : a[3:0];
      nb = sb ? b[7:4] : b[3:0];
      p  = 16'(na) * 16'(nb);
      return p << (4 * sh);
   endfunction

   always @(posedge clk) begin
      if (bus.dp_acc_clr)
         acc_m <= 16'd0;
      else if (bus.dp_acc_en)
         acc_m <= acc_m + part(bus.dp_a, bus.dp_b, bus.dp_sela, bus.dp_selb, bus.dp_shift_sel);
   end
   assign bus.dp_acc = acc_m;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   always begin
      logic [16:0] e;
      @(negedge clk);
      #1;
      if (!rst) begin
         sb_q.delete();
         exp_done = 8'd0;
      end else begin
         if (bus.req0_ready || bus.req1_ready)
            check("one_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
         if (bus.rsp_valid && bus.rsp_ready) begin
            check("sb_depth", 32'(sb_q.size()), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("rsp_id", 32'(bus.rsp_id), 32'(e[16]));
               check("rsp_data", 32'(bus.rsp_data), 32'(e[15:0]));
            end
            check("done_cnt_at_rsp", 32'(done_cnt), 32'(exp_done));
            exp_done = exp_done + 8'd1;
         end
      end
   end

   task automatic req_op(input bit id, input logic [7:0] a, input logic [7:0] b, output int t_acc);
      bit got = 1'b0;
      t_acc = -1;
      @(negedge clk);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
      end
      for (int n = 0; n < 400 && !got; n++) begin
         #1;
         if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
            got   = 1'b1;
            t_acc = cyc;
            sb_q.push_back({id, 16'(a) * 16'(b)});
         end else begin
            @(negedge clk);
         end
      end
      check("req_accepted", 32'(got), 1);
      @(negedge clk);
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      bit seen = 1'b0;
      n = 0;
      while (!seen && n < 100) begin
         #1;
         if (bus.rsp_valid) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
         @(negedge clk);
         #1;
         ok = !busy && sb_q.size() == 0 && !bus.req0_valid && !bus.req1_valid;
      end
      check("idle_reached", 32'(ok), 1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int          t0, t1, n, cnt;
      logic [3:0]  sa_tbl = 4'b1010;
      logic [3:0]  sb_tbl = 4'b1100;
      int          sh_tbl[4] = '{0, 1, 1, 2};

      rst = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_b = 8'd0;
      bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
      bus.rsp_ready  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done_cnt", 32'(done_cnt), 0);
      check("rst_dp_a", 32'(bus.dp_a), 0);
      check("rst_dp_b", 32'(bus.dp_b), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_data", 32'(bus.rsp_data), 0);
      check("rst_ctrl", 32'({bus.dp_acc_clr, bus.dp_acc_en, bus.dp_sela, bus.dp_selb, bus.dp_shift_sel}), 0);
      check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
      @(negedge clk);
      rst = 1'b1;

      // single request with cycle-by-cycle control checks
      req_op(1'b0, 8'd3, 8'd5, t0);
      #1;
      check("t1_clr", 32'(bus.dp_acc_clr), 1);
      check("t1_en_in_clr", 32'(bus.dp_acc_en), 0);
      check("t1_dp_a", 32'(bus.dp_a), 3);
      check("t1_dp_b", 32'(bus.dp_b), 5);
      check("t1_busy", 32'(busy), 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check("pp_en", 32'(bus.dp_acc_en), 1);
         check("pp_clr", 32'(bus.dp_acc_clr), 0);
         check("pp_sela", 32'(bus.dp_sela), 32'(sa_tbl[k]));
         check("pp_selb", 32'(bus.dp_selb), 32'(sb_tbl[k]));
         check("pp_shift", 32'(bus.dp_shift_sel), 32'(sh_tbl[k]));
      end
      @(negedge clk);
      #1;
      check("cap_en", 32'(bus.dp_acc_en), 0);
      check("cap_rsp_valid", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      #1;
      check("t7_rsp_valid", 32'(bus.rsp_valid), 1);
      check("t7_rsp_data", 32'(bus.rsp_data), 15);
      @(negedge clk);
      #1;
      check("t8_done_cnt", 32'(done_cnt), 1);
      check("t8_busy", 32'(busy), 0);

      // nibble extremes
      req_op(1'b1, 8'd255, 8'd255, t0);
      req_op(1'b1, 8'h10, 8'h01, t0);
      req_op(1'b1, 8'd0, 8'd200, t0);
      wait_idle();

      // backpressure: 200*100 = 20000 held for 20 cycles with req1 pending
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      req_op(1'b0, 8'd200, 8'd100, t0);
      wait_rsp(n);
      check("bp_latency", 32'(n), 6);
      fork
         req_op(1'b1, 8'd17, 8'd19, t1);
      join_none
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         check("bp_valid", 32'(bus.rsp_valid), 1);
         check("bp_data", 32'(bus.rsp_data), 20000);
         check("bp_id", 32'(bus.rsp_id), 0);
         check("bp_done_cnt", 32'(done_cnt), 4);
         check("bp_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      wait_idle();

      // reset during P2 of a requester-1 op
      req_op(1'b1, 8'd13, 8'd11, t0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("mr_busy", 32'(busy), 0);
      check("mr_rsp_valid", 32'(bus.rsp_valid), 0);
      check("mr_rsp_id", 32'(bus.rsp_id), 0);
      check("mr_dp_a", 32'(bus.dp_a), 0);
      check("mr_dp_b", 32'(bus.dp_b), 0);
      check("mr_done_cnt", 32'(done_cnt), 0);
      check("mr_ctrl", 32'({bus.dp_acc_clr, bus.dp_acc_en, bus.dp_sela, bus.dp_selb, bus.dp_shift_sel}), 0);
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         if (bus.rsp_valid) cnt++;
      end
      check("mr_no_rsp", 32'(cnt), 0);
      req_op(1'b0, 8'd9, 8'd14, t0);
      wait_rsp(n);
      check("mr_fresh_latency", 32'(n), 6);
      wait_idle();

      // contention from reset, RR_INIT = 0
      rst = 1'b0;
      fork
         req_op(1'b0, 8'd7, 8'd9, t0);
         req_op(1'b1, 8'd12, 8'd12, t1);
         begin
            @(negedge clk);
            #1;
            check("rst_ready_gated", 32'({bus.req0_ready, bus.req1_ready}), 0);
            @(negedge clk);
            rst = 1'b1;
         end
      join
      check("rr_req0_first", 32'(t0 < t1), 1);
      check("rr_gap", 32'(t1 - t0), 8);
      fork
         req_op(1'b0, 8'd21, 8'd3, t0);
         req_op(1'b1, 8'd2, 8'd50, t1);
      join
      check("rr_alternate", 32'(t0 < t1), 1);
      wait_idle();

      // counter wrap over 256 back-to-back operations
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] a;
         logic [7:0] b;
         a = 8'(i);
         b = 8'(i * 37 + 11);
         req_op(1'(i), a, b, t0);
      end
      wait_idle();
      check("wrap_done_cnt", 32'(done_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
